// File: rtl/fhc_pkg.sv
// Opcode map, instruction field positions and register-usage decode shared by
// the fetch hazard controller and its EX shadow register.
package fhc_pkg;

  localparam logic [4:0] OP_NOP = 5'h00;
  localparam logic [4:0] OP_ADD = 5'h01;
  localparam logic [4:0] OP_SUB = 5'h02;
  localparam logic [4:0] OP_AND = 5'h03;
  localparam logic [4:0] OP_OR  = 5'h04;
  localparam logic [4:0] OP_XOR = 5'h05;
  localparam logic [4:0] OP_SLT = 5'h06;
  localparam logic [4:0] OP_LDI = 5'h08;
  localparam logic [4:0] OP_LD  = 5'h10;
  localparam logic [4:0] OP_ST  = 5'h11;
  localparam logic [4:0] OP_JMP = 5'h18;
  localparam logic [4:0] OP_BEQ = 5'h19;
  localparam logic [4:0] OP_BNE = 5'h1A;
  localparam logic [4:0] OP_HLT = 5'h1F;

  localparam int OP_HI  = 23;
  localparam int OP_LO  = 19;
  localparam int RD_HI  = 18;
  localparam int RD_LO  = 16;
  localparam int RS_HI  = 15;
  localparam int RS_LO  = 13;
  localparam int RT_HI  = 12;
  localparam int RT_LO  = 10;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fhc_state_e;

  function automatic logic is_alu(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT: is_alu = 1'b1;
      default:                                       is_alu = 1'b0;
    endcase
  endfunction

  function automatic logic reads_rs(input logic [4:0] op);
    reads_rs = is_alu(op) || (op == OP_ST) || (op == OP_BEQ) ||
               (op == OP_BNE) || (op == OP_LD);
  endfunction

  function automatic logic reads_rt(input logic [4:0] op);
    reads_rt = is_alu(op) || (op == OP_ST) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  function automatic logic writes_rd(input logic [4:0] op);
    writes_rd = is_alu(op) || (op == OP_LDI) || (op == OP_LD);
  endfunction

endpackage

// File: rtl/fhc_ex_shadow.sv
// One-entry shadow of the instruction in EX: class, destination and branch
// target, with bubble insertion on flush or load-use stall.
module fhc_ex_shadow
  import fhc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load_bubble,
  input  logic [4:0] id_op,
  input  logic [2:0] id_rd,
  input  logic [7:0] id_tgt,
  output logic       ex_valid,
  output logic [4:0] ex_op,
  output logic [2:0] ex_rd,
  output logic [7:0] ex_tgt
);

  logic       ex_valid_r;
  logic [4:0] ex_op_r;
  logic [2:0] ex_rd_r;
  logic [7:0] ex_tgt_r;

  // Advance ID into EX every clock; non-writers carry rd=0 so they never match
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_r <= 1'b0;
      ex_op_r    <= OP_NOP;
      ex_rd_r    <= 3'd0;
      ex_tgt_r   <= 8'h00;
    end else if (load_bubble) begin
      ex_valid_r <= 1'b0;
      ex_op_r    <= OP_NOP;
      ex_rd_r    <= 3'd0;
      ex_tgt_r   <= 8'h00;
    end else begin
      ex_valid_r <= 1'b1;
      ex_op_r    <= id_op;
      ex_rd_r    <= writes_rd(id_op) ? id_rd : 3'd0;
      ex_tgt_r   <= id_tgt;
    end
  end

  assign ex_valid = ex_valid_r;
  assign ex_op    = ex_op_r;
  assign ex_rd    = ex_rd_r;
  assign ex_tgt   = ex_tgt_r;

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// Fetch-steering control: branch resolution in EX, load-use stall, JMP
// redirect, halt state and a saturating stall-cycle counter.
module fetch_hazard_ctrl
  import fhc_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [23:0]            ins,
  input  logic                   ex_zero,
  output logic [7:0]             jmp_loc,
  output logic                   pc_mux_sel,
  output logic                   Stall,
  output logic                   Stall_pm,
  output logic                   flush_id,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};
  localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  logic [4:0]             id_op_s;
  logic [2:0]             id_rd_s;
  logic [2:0]             id_rs_s;
  logic [2:0]             id_rt_s;
  logic [7:0]             id_imm_s;
  logic                   ex_valid_s;
  logic [4:0]             ex_op_s;
  logic [2:0]             ex_rd_s;
  logic [7:0]             ex_tgt_s;
  logic                   branch_taken_s;
  logic                   load_use_s;
  fhc_state_e             state_r;
  fhc_state_e             state_next_s;
  logic [STALL_CNT_W-1:0] stall_cnt_r;

  assign id_op_s  = ins[OP_HI:OP_LO];
  assign id_rd_s  = ins[RD_HI:RD_LO];
  assign id_rs_s  = ins[RS_HI:RS_LO];
  assign id_rt_s  = ins[RT_HI:RT_LO];
  assign id_imm_s = ins[IMM_HI:IMM_LO];

  fhc_ex_shadow u_ex_shadow (
    .clk         (clk),
    .reset       (reset),
    .load_bubble (flush_id | Stall),
    .id_op       (id_op_s),
    .id_rd       (id_rd_s),
    .id_tgt      (id_imm_s),
    .ex_valid    (ex_valid_s),
    .ex_op       (ex_op_s),
    .ex_rd       (ex_rd_s),
    .ex_tgt      (ex_tgt_s)
  );

  // Hazard detection against the EX shadow
  always_comb begin
    branch_taken_s = ex_valid_s &&
                     (((ex_op_s == OP_BEQ) && ex_zero) || ((ex_op_s == OP_BNE) && !ex_zero));
    load_use_s     = ex_valid_s && (ex_op_s == OP_LD) && (ex_rd_s != 3'd0) &&
                     ((reads_rs(id_op_s) && (id_rs_s == ex_rd_s)) ||
                      (reads_rt(id_op_s) && (id_rt_s == ex_rd_s)));
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state: HALT is left only through reset
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if ((id_op_s == OP_HLT) && !flush_id) begin
          state_next_s = ST_HALT;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_HALT: state_next_s = ST_HALT;
      default: state_next_s = ST_RUN;
    endcase
  end

  // Priority output decode; forced quiet while reset is held
  always_comb begin
    jmp_loc    = 8'h00;
    pc_mux_sel = 1'b0;
    Stall      = 1'b0;
    Stall_pm   = 1'b0;
    flush_id   = 1'b0;
    if (reset) begin
      case (state_r)
        ST_HALT: begin
          Stall    = 1'b1;
          Stall_pm = 1'b1;
          flush_id = 1'b1;
        end
        ST_RUN: begin
          if (branch_taken_s) begin
            pc_mux_sel = 1'b1;
            jmp_loc    = ex_tgt_s;
            flush_id   = 1'b1;
          end else if (load_use_s) begin
            Stall    = 1'b1;
            Stall_pm = 1'b1;
          end else if (id_op_s == OP_JMP) begin
            pc_mux_sel = 1'b1;
            jmp_loc    = id_imm_s;
          end else begin
            jmp_loc = 8'h00;
          end
        end
        default: begin
          jmp_loc = 8'h00;
        end
      endcase
    end else begin
      jmp_loc = 8'h00;
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= {STALL_CNT_W{1'b0}};
    end else if (Stall && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign halted    = (state_r == ST_HALT);
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Directed scenarios plus a randomized instruction stream checked against a
// behavioural model of the fetch hazard controller.
module tb_fetch_hazard_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [23:0]   ins = 24'hC00040;
  logic          ex_zero = 1'b0;
  logic [7:0]    jmp_loc;
  logic          pc_mux_sel;
  logic          Stall;
  logic          Stall_pm;
  logic          flush_id;
  logic          halted;
  logic [CW-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  // Output bundle: {pc_mux_sel, Stall, Stall_pm, flush_id, halted, jmp_loc}
  logic [12:0] obs;
  assign obs = {pc_mux_sel, Stall, Stall_pm, flush_id, halted, jmp_loc};

  always #5 clk = ~clk;

  fetch_hazard_ctrl #(.STALL_CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .ins        (ins),
    .ex_zero    (ex_zero),
    .jmp_loc    (jmp_loc),
    .pc_mux_sel (pc_mux_sel),
    .Stall      (Stall),
    .Stall_pm   (Stall_pm),
    .flush_id   (flush_id),
    .halted     (halted),
    .stall_cnt  (stall_cnt)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== 13'h0000) begin
      errors++;
      $display("FAIL reset_outputs: got %h want %h", obs, 13'h0000);
    end
    checks++;
    if (stall_cnt !== 4'h0) begin
      errors++;
      $display("FAIL reset_cnt: got %h want %h", stall_cnt, 4'h0);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== 13'h1040) begin
      errors++;
      $display("FAIL reset_release_jmp: got %h want %h", obs, 13'h1040);
    end
    next_cycle();
  endtask

  task automatic test_load_use();
    logic [23:0] seq [6];
    logic [12:0] exp_o [6];
    logic [3:0]  exp_c [6];
    seq   = '{24'h830000, 24'h0C6400, 24'h0C6400, 24'h830000, 24'h836000, 24'h836000};
    exp_o = '{13'h0000,   13'h0C00,   13'h0000,   13'h0000,   13'h0C00,   13'h0000};
    exp_c = '{4'h0,       4'h0,       4'h1,       4'h1,       4'h1,       4'h2};
    for (int i = 0; i < 6; i++) begin
      ins = seq[i];
      @(negedge clk);
      checks++;
      if (obs !== exp_o[i]) begin
        errors++;
        $display("FAIL load_use_out[%0d]: got %h want %h", i, obs, exp_o[i]);
      end
      checks++;
      if (stall_cnt !== exp_c[i]) begin
        errors++;
        $display("FAIL load_use_cnt[%0d]: got %h want %h", i, stall_cnt, exp_c[i]);
      end
      next_cycle();
    end
    ins = 24'h000000;
    next_cycle();
  endtask

  task automatic test_branch(input string name, input logic [23:0] br, input logic zero,
                             input logic [12:0] exp_resolve, input logic [12:0] exp_after);
    ins = br;
    ex_zero = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== 13'h0000) begin
      errors++;
      $display("FAIL %s_id: got %h want %h", name, obs, 13'h0000);
    end
    next_cycle();
    ins = 24'hC00040;
    ex_zero = zero;
    @(negedge clk);
    checks++;
    if (obs !== exp_resolve) begin
      errors++;
      $display("FAIL %s_resolve: got %h want %h", name, obs, exp_resolve);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (obs !== exp_after) begin
      errors++;
      $display("FAIL %s_after: got %h want %h", name, obs, exp_after);
    end
    next_cycle();
    ins = 24'h000000;
    ex_zero = 1'b0;
    next_cycle();
  endtask

  task automatic test_conflict();
    ins = 24'h830000;
    next_cycle();
    ins = 24'hC00040;
    ex_zero = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== 13'h1040) begin
      errors++;
      $display("FAIL conflict_ld_jmp: got %h want %h", obs, 13'h1040);
    end
    next_cycle();
    ins = 24'h000000;
    ex_zero = 1'b0;
    next_cycle();
  endtask

  task automatic test_halt();
    int exp_cnt;
    ins = 24'hF80000;
    @(negedge clk);
    checks++;
    if (obs !== 13'h0000) begin
      errors++;
      $display("FAIL halt_in_id: got %h want %h", obs, 13'h0000);
    end
    next_cycle();
    ins = 24'h000000;
    for (int k = 0; k < 16; k++) begin
      exp_cnt = (2 + k > 15) ? 15 : 2 + k;
      @(negedge clk);
      checks++;
      if (obs !== 13'h0F00) begin
        errors++;
        $display("FAIL halt_out[%0d]: got %h want %h", k, obs, 13'h0F00);
      end
      checks++;
      if (stall_cnt !== exp_cnt[3:0]) begin
        errors++;
        $display("FAIL halt_cnt[%0d]: got %h want %h", k, stall_cnt, exp_cnt[3:0]);
      end
      next_cycle();
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({obs, stall_cnt} !== 17'h00000) begin
      errors++;
      $display("FAIL halt_async_reset: got %h want %h", {obs, stall_cnt}, 17'h00000);
    end
    next_cycle();
  endtask

  function automatic logic [7:0] read_mask(input logic [23:0] w);
    logic [4:0] op;
    logic [7:0] m;
    op = w[23:19];
    m  = 8'h00;
    if ((op >= 5'h01 && op <= 5'h06) || op == 5'h11 || op == 5'h19 || op == 5'h1A)
      m = (8'h01 << w[15:13]) | (8'h01 << w[12:10]);
    else if (op == 5'h10)
      m = 8'h01 << w[15:13];
    return m;
  endfunction

  task automatic test_random();
    logic [4:0]  op_tab [14];
    logic        m_v;
    logic [4:0]  m_op;
    logic [2:0]  m_rd;
    logic [7:0]  m_tgt;
    int          m_cnt;
    logic        taken;
    logic        lu;
    logic [7:0]  mask;
    logic [12:0] exp_o;
    op_tab = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h08,
               5'h10, 5'h11, 5'h18, 5'h19, 5'h1A, 5'h0C};
    reset = 1'b0;
    ins = 24'h000000;
    next_cycle();
    next_cycle();
    reset = 1'b1;
    m_v = 1'b0; m_op = 5'h00; m_rd = 3'd0; m_tgt = 8'h00; m_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      ins = {op_tab[$urandom_range(0, 13)], 1'b0, 2'($urandom_range(0, 3)),
             1'b0, 2'($urandom_range(0, 3)), 1'b0, 2'($urandom_range(0, 3)),
             2'b00, 8'($urandom)};
      ex_zero = 1'($urandom);
      @(negedge clk);
      taken = m_v && ((m_op == 5'h19 && ex_zero) || (m_op == 5'h1A && !ex_zero));
      mask  = read_mask(ins);
      lu    = m_v && m_op == 5'h10 && m_rd != 3'd0 && mask[m_rd];
      if (taken)                      exp_o = {5'b10010, m_tgt};
      else if (lu)                    exp_o = 13'h0C00;
      else if (ins[23:19] == 5'h18)   exp_o = {5'b10000, ins[7:0]};
      else                            exp_o = 13'h0000;
      checks++;
      if (obs !== exp_o) begin
        errors++;
        $display("FAIL rand_out[%0d] ins=%h: got %h want %h", i, ins, obs, exp_o);
      end
      checks++;
      if (stall_cnt !== m_cnt[3:0]) begin
        errors++;
        $display("FAIL rand_cnt[%0d]: got %h want %h", i, stall_cnt, m_cnt[3:0]);
      end
      next_cycle();
      if (taken || lu) begin
        m_v = 1'b0;
      end else begin
        m_v = 1'b1; m_op = ins[23:19]; m_rd = ins[18:16]; m_tgt = ins[7:0];
      end
      if (lu && m_cnt < 15) m_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch("beq_taken", 24'hC82820, 1'b1, 13'h1220, 13'h1040);
    test_branch("beq_not_taken", 24'hC82820, 1'b0, 13'h1040, 13'h1040);
    test_branch("bne_taken", 24'hD02833, 1'b0, 13'h1233, 13'h1040);
    test_conflict();
    test_halt();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_hazard_ctrl.md
Name: fetch_hazard_ctrl

Overview:
Control-side counterpart of the fetch stage. Consumes the 24-bit instruction delivered to decode (ID) and produces the fetch-steering controls: jmp_loc, pc_mux_sel, Stall and Stall_pm.
Keeps a one-entry EX shadow register (opcode class, rd, branch target) to detect load-use hazards and resolve conditional branches.
Also provides an ID flush, a halt state and a saturating stall counter.

Parameters:
STALL_CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low (0 = held in reset)
ins  in  24  instruction currently in ID (fetch output; 0 during reset)
ex_zero  in  1  ALU zero flag of the instruction currently in EX
jmp_loc  out  8  absolute fetch target
pc_mux_sel  out  1  1 = fetch from jmp_loc
Stall  out  1  1 = PC re-fetches the held address
Stall_pm  out  1  1 = fetch re-presents the previous instruction
flush_id  out  1  1 = the ID instruction is turned into a bubble
halted  out  1  1 = core halted
stall_cnt  out  STALL_CNT_W  count of Stall=1 cycles, saturating

Behaviour:
- Instruction fields: opcode ins[23:19], rd [18:16], rs [15:13], rt [12:10], imm8 [7:0].
- Opcodes: NOP 00, ADD 01, SUB 02, AND 03, OR 04, XOR 05, SLT 06, LDI 08, LD 10, ST 11, JMP 18, BEQ 19, BNE 1A, HLT 1F. Any other opcode is handled as NOP.
- Register reads:
  - ALU ops, ST, BEQ, BNE read rs and rt.
  - LD reads rs.
  - NOP, LDI, JMP, HLT read none.
- Register writes: ALU ops, LDI and LD write rd. r0 never causes a hazard.
- EX shadow register: ex_valid, ex_op, ex_rd, ex_tgt. It loads from ID each clock. It loads a bubble (ex_valid=0) when flush_id=1 or a load-use stall is active.
- FSM states: RUN and HALT.
  - RUN -> HALT when a HLT is in ID and flush_id=0.
  - HALT -> RUN only through reset.
- Output decode. Outputs are combinational from ins, the EX shadow register and the state, evaluated in priority order:
  1. HALT: Stall=1, Stall_pm=1, pc_mux_sel=0, flush_id=1.
  2. Branch taken in EX. Condition: ex_valid and ((ex_op=BEQ and ex_zero) or (ex_op=BNE and !ex_zero)). Drives pc_mux_sel=1, jmp_loc=ex_tgt, flush_id=1, Stall=0, Stall_pm=0. This wins over any ID event (ID holds a wrong-path instruction).
  3. Load-use. Condition: ex_valid, ex_op=LD, ex_rd!=0, and the ID instruction reads ex_rd. Drives Stall=1, Stall_pm=1, pc_mux_sel=0. The ID instruction is retained and re-evaluated next cycle.
  4. JMP in ID: pc_mux_sel=1, jmp_loc=imm8. No flush, because the target is fetched on the next edge.
  5. Otherwise all outputs are 0 and jmp_loc=0.
- jmp_loc is 0 whenever pc_mux_sel=0.
- stall_cnt increments by 1 on each clock edge where Stall=1. It saturates at all-ones and never wraps.
- Reset (asynchronous, reset=0):
  - State=RUN, ex_valid=0, ex_op=NOP, ex_rd=0, ex_tgt=0, stall_cnt=0.
  - All outputs read 0.
  - Reset asserted mid-stall or in HALT clears these immediately, without waiting for a clock.
- Latency:
  - Hazard and branch controls act in the same cycle as the triggering state.
  - A load-use stall lasts exactly one cycle.
  - A taken branch costs exactly one flushed ID slot.

Decomposition:
- Package fhc_pkg holds the opcode localparams, the field bit positions, and functions reads_rs, reads_rt and writes_rd.
- One sub-module, fhc_ex_shadow: the EX shadow register with async active-low reset and bubble insert.
- FSM, priority decode and stall counter stay in the top module.

Test Plan:
- Reset: reset=0 with ins=24'hC00040 -> all outputs 0, stall_cnt=0. Release reset -> pc_mux_sel=1 and jmp_loc=8'h40 in the same cycle.
- Load-use: ins=24'h830000 (LD r3), then ins=24'h0C6400 (ADD r4,r3,r1) -> Stall=Stall_pm=1 for exactly 1 cycle, EX receives a bubble, stall_cnt=1. The next cycle shows no stall.
- Taken branch: ins=24'hC82820 (BEQ r1,r2,0x20), next cycle ex_zero=1 with ins=24'hC00040 in ID -> pc_mux_sel=1, jmp_loc=8'h20, flush_id=1. The JMP is ignored.
- Not-taken branch: same sequence with ex_zero=0 -> no flush; JMP in ID yields jmp_loc=8'h40.
- Halt and counter: ins=24'hF80000 -> halted=1 with Stall=1 on every following cycle. With STALL_CNT_W=4, stall_cnt stops at 4'hF. Asserting reset=0 mid-HALT -> halted=0 and stall_cnt=0 asynchronously.
- Conflicts: LD r3 in EX, the branch condition in EX false, and ins=24'hC00040 in ID -> no stall (JMP reads no register), pc_mux_sel=1.
